// File: rtl/reg_file_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Parametrised register file with two combinational read ports,
//            two synchronous write ports (port A has priority on a shared
//            address), optional write-to-read bypass, optional hardwired
//            zero register and a sequenced bulk-clear sweep.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            RegWrite/write_register/data_in     - write port A (priority)
//            RegWriteB/write_registerB/data_inB  - write port B
//            raddrA/raddrB        - read addresses
//            data_outA/data_outB  - combinational read data
//            clear                - one-cycle request to start the sweep
//            busy                 - high while the sweep is running
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
  parameter int W        = 8,
  parameter int A        = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RegWrite,
  input  logic [A-1:0] write_register,
  input  logic [W-1:0] data_in,
  input  logic         RegWriteB,
  input  logic [A-1:0] write_registerB,
  input  logic [W-1:0] data_inB,
  input  logic [A-1:0] raddrA,
  input  logic [A-1:0] raddrB,
  output logic [W-1:0] data_outA,
  output logic [W-1:0] data_outB,
  input  logic         clear,
  output logic         busy
);

  localparam int DEPTH = 2**A;
  localparam logic [A-1:0] c_LAST = {A{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [A-1:0]   r_cnt;
  logic [W-1:0]   r_mem [DEPTH];

  logic           w_busy;
  logic           w_zeroA;
  logic           w_zeroB;
  logic           w_commitA;
  logic           w_commitB;
  logic [A-1:0]   w_raddr [2];
  logic [W-1:0]   w_rdata [2];

  assign w_busy = (r_state == S_SWEEP);

  // Writes aimed at the hardwired zero register are discarded outright.
  assign w_zeroA = (ZERO_REG != 0) && (write_register  == '0);
  assign w_zeroB = (ZERO_REG != 0) && (write_registerB == '0);

  // A "commit" is a write that will really land at the next edge; the same
  // qualification drives both the storage update and the bypass match.
  assign w_commitA = RegWrite  && !w_busy && !reset && !w_zeroA;
  assign w_commitB = RegWriteB && !w_busy && !reset && !w_zeroB &&
                     !(w_commitA && (write_register == write_registerB));

  // Clear sequencer: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear)           w_state_nxt = S_SWEEP;
      S_SWEEP: if (r_cnt == c_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, sweep counter and storage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_busy) begin
        // The counter wraps to 0 on the last entry, but the FSM has left
        // SWEEP by then, so no second pass starts.
        r_mem[r_cnt] <= '0;
        r_cnt        <= r_cnt + 1'b1;
      end else begin
        if (clear) begin
          r_cnt <= '0;
        end
        if (w_commitB) begin
          r_mem[write_registerB] <= data_inB;
        end
        if (w_commitA) begin
          r_mem[write_register] <= data_in;
        end
      end
    end
  end

  assign w_raddr[0] = raddrA;
  assign w_raddr[1] = raddrB;

  // Read muxes: later assignments take precedence, so the order below is
  // lowest priority (storage) to highest (zero register).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = r_mem[w_raddr[p]];
      if ((BYPASS != 0) && w_commitB && (write_registerB == w_raddr[p])) begin
        w_rdata[p] = data_inB;
      end
      if ((BYPASS != 0) && w_commitA && (write_register == w_raddr[p])) begin
        w_rdata[p] = data_in;
      end
      if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
        w_rdata[p] = '0;
      end
    end
  end

  assign data_outA = w_rdata[0];
  assign data_outB = w_rdata[1];
  assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Self-checking bench for reg_file_mp. Three instances share one
//            stimulus stream: bypass on, bypass off, bypass on + zero
//            register. A behavioural model (plain arrays) predicts every
//            read port and busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, RegWrite, RegWriteB, clear;
  logic [3:0] wa, wb, ra, rb;
  logic [7:0] da, db;
  logic [7:0] oa0, ob0, oa1, ob1, oa2, ob2;
  logic       bz0, bz1, bz2;

  reg_file_mp #(.W(8), .A(4), .BYPASS(1), .ZERO_REG(0)) u_byp (
    .clk(clk), .reset(reset),
    .RegWrite(RegWrite), .write_register(wa), .data_in(da),
    .RegWriteB(RegWriteB), .write_registerB(wb), .data_inB(db),
    .raddrA(ra), .raddrB(rb), .data_outA(oa0), .data_outB(ob0),
    .clear(clear), .busy(bz0)
  );

  reg_file_mp #(.W(8), .A(4), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
    .clk(clk), .reset(reset),
    .RegWrite(RegWrite), .write_register(wa), .data_in(da),
    .RegWriteB(RegWriteB), .write_registerB(wb), .data_inB(db),
    .raddrA(ra), .raddrB(rb), .data_outA(oa1), .data_outB(ob1),
    .clear(clear), .busy(bz1)
  );

  reg_file_mp #(.W(8), .A(4), .BYPASS(1), .ZERO_REG(1)) u_zero (
    .clk(clk), .reset(reset),
    .RegWrite(RegWrite), .write_register(wa), .data_in(da),
    .RegWriteB(RegWriteB), .write_registerB(wb), .data_inB(db),
    .raddrA(ra), .raddrB(rb), .data_outA(oa2), .data_outB(ob2),
    .clear(clear), .busy(bz2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: contents per instance, plus sweep progress.
  logic [7:0] mm [3][16];
  bit         m_busy;
  int         m_k;

  function automatic bit byp(int w);
    return w != 1;
  endfunction

  function automatic bit zr(int w);
    return w == 2;
  endfunction

  function automatic logic [7:0] exp_rd(int w, logic [3:0] addr);
    if (zr(w) && addr == 4'd0) return 8'd0;
    if (byp(w) && !m_busy && !reset) begin
      if (RegWrite  && wa == addr) return da;
      if (RegWriteB && wb == addr) return db;
    end
    return mm[w][addr];
  endfunction

  function automatic logic [7:0] out_a(int w);
    case (w)
      0: return oa0;
      1: return oa1;
      default: return oa2;
    endcase
  endfunction

  function automatic logic [7:0] out_b(int w);
    case (w)
      0: return ob0;
      1: return ob1;
      default: return ob2;
    endcase
  endfunction

  function automatic logic out_busy(int w);
    case (w)
      0: return bz0;
      1: return bz1;
      default: return bz2;
    endcase
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
  endtask

  // Model update for one rising edge, using the inputs present at the edge.
  task automatic model_edge();
    if (reset) begin
      for (int w = 0; w < 3; w++)
        for (int i = 0; i < 16; i++) mm[w][i] = 8'd0;
      m_busy = 0;
      m_k    = 0;
    end else if (m_busy) begin
      for (int w = 0; w < 3; w++) mm[w][m_k] = 8'd0;
      m_k++;
      if (m_k == 16) m_busy = 0;
    end else begin
      for (int w = 0; w < 3; w++) begin
        if (RegWriteB && !(zr(w) && wb == 4'd0) && !(RegWrite && wa == wb))
          mm[w][wb] = db;
        if (RegWrite && !(zr(w) && wa == 4'd0))
          mm[w][wa] = da;
      end
      if (clear) begin
        m_busy = 1;
        m_k    = 0;
      end
    end
  endtask

  task automatic check_outputs(string where);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("%s busy dut%0d", where, w), {7'd0, out_busy(w)}, {7'd0, m_busy});
      chk($sformatf("%s rdA dut%0d addr%0d", where, w, ra), out_a(w), exp_rd(w, ra));
      chk($sformatf("%s rdB dut%0d addr%0d", where, w, rb), out_b(w), exp_rd(w, rb));
    end
  endtask

  // Inputs are set one time unit after an edge; check before and after the next edge.
  task automatic step();
    #1;
    check_outputs("pre");
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("post");
  endtask

  task automatic scan(string where);
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i);
      rb = 4'(15 - i);
      #0.2;
      for (int w = 0; w < 3; w++) begin
        chk($sformatf("%s scanA dut%0d R%0d", where, w, i), out_a(w), exp_rd(w, ra));
        chk($sformatf("%s scanB dut%0d R%0d", where, w, 15 - i), out_b(w), exp_rd(w, rb));
      end
    end
  endtask

  task automatic drive(logic rst, logic weA, logic [3:0] aA, logic [7:0] dA,
                       logic weB, logic [3:0] aB, logic [7:0] dB, logic clr,
                       logic [3:0] rA, logic [3:0] rB);
    reset = rst; RegWrite = weA; wa = aA; da = dA;
    RegWriteB = weB; wb = aB; db = dB; clear = clr; ra = rA; rb = rB;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1);
  end

  int busy_cycles;

  initial begin
    // Reset with a write present in the same cycle: the write must be lost.
    reset = 1; RegWrite = 1; wa = 4'd3; da = 8'd9;
    RegWriteB = 1; wb = 4'd4; db = 8'd7; clear = 0; ra = 4'd3; rb = 4'd4;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("reset");
    scan("after_reset");

    // Basic write/read and a disabled write.
    drive(0, 1, 4'd14, 8'd255, 1, 4'd9, 8'd200, 0, 4'd14, 4'd9);
    drive(0, 0, 4'd3, 8'd155, 0, 4'd0, 8'd0, 0, 4'd3, 4'd14);
    scan("basic");

    // Dual write, then same-address collision.
    drive(0, 1, 4'd5, 8'h11, 1, 4'd6, 8'h22, 0, 4'd5, 4'd6);
    drive(0, 1, 4'd7, 8'h33, 1, 4'd7, 8'h44, 0, 4'd7, 4'd7);
    scan("collision");

    // Bypass priority: R2 holds 0F, then both ports write R2 together.
    drive(0, 1, 4'd2, 8'h0F, 0, 4'd0, 8'd0, 0, 4'd2, 4'd2);
    drive(0, 1, 4'd2, 8'hA5, 1, 4'd2, 8'h5A, 0, 4'd2, 4'd2);
    drive(0, 0, 4'd0, 8'd0, 1, 4'd11, 8'h5C, 0, 4'd11, 4'd2);
    scan("bypass");

    // Zero register: both ports write FF to R0.
    drive(0, 1, 4'd0, 8'hFF, 1, 4'd0, 8'hFF, 0, 4'd0, 4'd0);
    scan("zero");

    // Randomised writes and reads, no clear.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] a1, a2;
      a1 = 4'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 40) == 0, 1'($urandom), a1, 8'($urandom),
            1'($urandom), a2, 8'($urandom), 0,
            ($urandom_range(0, 1) == 0) ? a1 : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? a2 : 4'($urandom_range(0, 15)));
    end
    scan("random");

    // Fill R0..R15 with 80+i, then sweep.
    for (int i = 0; i < 8; i++)
      drive(0, 1, 4'(i), 8'(8'h80 + i), 1, 4'(i + 8), 8'(8'h88 + i), 0, 4'(i), 4'(i + 8));
    scan("filled");
    // The write issued alongside clear still commits.
    drive(0, 1, 4'd3, 8'h3C, 0, 4'd0, 8'd0, 1, 4'd3, 4'd15);
    busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      if (bz0) busy_cycles++;
      scan($sformatf("sweep%0d", c));
      if (c < 14)
        drive(0, 1, 4'd15, 8'h77, 1, 4'd14, 8'h66, c == 7, 4'd15, 4'd14);
      else
        idle(1);
    end
    chk("sweep_busy_cycles", 8'(busy_cycles), 8'd16);
    scan("sweep_done");

    // Back-to-back sweeps: a new clear is taken right after busy falls.
    drive(0, 1, 4'd1, 8'h12, 1, 4'd2, 8'h34, 0, 4'd1, 4'd2);
    drive(0, 0, 4'd0, 8'd0, 0, 4'd0, 8'd0, 1, 4'd1, 4'd2);
    idle(16);
    drive(0, 1, 4'd9, 8'h99, 0, 4'd0, 8'd0, 1, 4'd9, 4'd0);
    scan("second_sweep_start");

    // Reset at sweep cycle 5 aborts; clear is accepted on the next cycle.
    idle(4);
    drive(1, 0, 4'd0, 8'd0, 0, 4'd0, 8'd0, 0, 4'd0, 4'd15);
    scan("reset_mid_sweep");
    drive(0, 0, 4'd0, 8'd0, 0, 4'd0, 8'd0, 1, 4'd0, 4'd15);
    for (int i = 0; i < 17; i++)
      drive(0, 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom),
            4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    scan("after_third_sweep");

    // Mixed random traffic including clears and occasional resets.
    for (int i = 0; i < 200; i++) begin
      logic [3:0] a1, a2;
      a1 = 4'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 60) == 0, 1'($urandom), a1, 8'($urandom),
            1'($urandom), a2, 8'($urandom), $urandom_range(0, 30) == 0,
            ($urandom_range(0, 1) == 0) ? a1 : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? a2 : 4'($urandom_range(0, 15)));
      if (i % 25 == 24) scan($sformatf("mixed%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
